// File: rtl/pipeline_hazard_controller_pkg.sv
// pipeline_hazard_controller_pkg: shared state, forwarding encodings and tracker type
package pipeline_hazard_controller_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic       regwrite;
      logic       memread;
   } tracker_t;

   // $0 is hardwired, so a write to it never produces a value worth forwarding
   function automatic logic writes_reg(input tracker_t t, input logic [4:0] r);
      return t.valid && t.regwrite && (t.dst != 5'd0) && (t.dst == r);
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// forward_select: picks the EX operand source for one source register
module forward_select
   import pipeline_hazard_controller_pkg::*;
(
   input  tracker_t   mem,
   input  tracker_t   wb,
   input  logic [4:0] src,
   output logic [1:0] sel
);

   // the younger producer in MEM wins over the older one in WB
   assign sel = writes_reg(mem, src) ? FWD_MEM :
                writes_reg(wb, src)  ? FWD_WB  : FWD_RF;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush/freeze control, EX forwarding and perf counters
// for a five-stage pipeline, tracking EX/MEM/WB instruction summaries internally.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       id_dst,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_branch_taken,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_hold,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   tracker_t         ex_q, mem_q, wb_q, ex_d;
   state_t           state_q, state_d;
   logic             load_use, stall_evt, flush_evt;
   logic [1:0]       sel_a, sel_b;
   logic [CNT_W-1:0] stall_q, flush_q;

   assign load_use = (state_q != LOAD_STALL) && id_valid && ex_q.valid && ex_q.memread &&
                     (ex_q.dst != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_q.dst)) || (id_uses_rt && (id_rt == ex_q.dst)));

   always_comb begin
      state_d     = RUN;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_hold   = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;
      if (rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (dmem_busy) begin
         state_d    = MEM_WAIT;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         pipe_hold  = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_evt   = 1'b1;
      end else if (load_use) begin
         state_d     = LOAD_STALL;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall_evt   = 1'b1;
      end
   end

   // a bubble keeps the ID register fields so the held reader still sees MEM forwarding
   always_comb begin
      ex_d          = '{valid: id_valid, rs: id_rs, rt: id_rt, dst: id_dst,
                        regwrite: id_regwrite, memread: id_memread};
      ex_d.valid    = id_valid && !idex_bubble;
   end

   forward_select u_fwd_a (.mem(mem_q), .wb(wb_q), .src(ex_q.rs), .sel(sel_a));
   forward_select u_fwd_b (.mem(mem_q), .wb(wb_q), .src(ex_q.rt), .sel(sel_b));

   assign fwd_a     = rst ? FWD_RF : sel_a;
   assign fwd_b     = rst ? FWD_RF : sel_b;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         if (!pipe_hold) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
         end
         if (stall_evt && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
         if (flush_evt && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_pipeline_hazard_controller;
   localparam logic [4:0] C_RUN   = 5'b11000;
   localparam logic [4:0] C_STALL = 5'b00010;
   localparam logic [4:0] C_BR    = 5'b11110;
   localparam logic [4:0] C_HOLD  = 5'b00001;
   localparam logic [4:0] C_RST   = 5'b00110;

   typedef struct {
      string       nm;
      logic [8:0]  ctl;
      logic [15:0] sc;
      logic [15:0] fc;
      logic [3:0]  ssc;
   } exp_t;

   logic        clk, rst, id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
   logic        ex_branch_taken, dmem_busy;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pcw, s_ifw, s_fl, s_bub, s_hold;
   logic [1:0]  s_fa, s_fb;
   logic [3:0]  s_sc, s_fc;
   exp_t        q[$];
   exp_t        m;
   int          checks = 0;
   int          errors = 0;

   pipeline_hazard_controller dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_controller #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread),
      .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
      .pc_write(s_pcw), .ifid_write(s_ifw), .ifid_flush(s_fl),
      .idex_bubble(s_bub), .pipe_hold(s_hold), .fwd_a(s_fa), .fwd_b(s_fb),
      .stall_cnt(s_sc), .flush_cnt(s_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         m = q.pop_front();
         checks++;
         if ({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, fwd_a, fwd_b} !== m.ctl ||
             stall_cnt !== m.sc || flush_cnt !== m.fc || s_sc !== m.ssc) begin
            errors++;
            $display("FAIL %s: got ctl=%b stall=%0d flush=%0d small_stall=%0d, want ctl=%b stall=%0d flush=%0d small_stall=%0d",
                     m.nm, {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, fwd_a, fwd_b},
                     stall_cnt, flush_cnt, s_sc, m.ctl, m.sc, m.fc, m.ssc);
         end
      end
   end

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dst = dst; id_regwrite = rw; id_memread = mr;
   endtask

   task automatic nop();     set_id(0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic lw8();     set_id(1, 1, 0, 1, 0, 8, 1, 1); endtask
   task automatic add9();    set_id(1, 8, 10, 1, 1, 9, 1, 0); endtask
   task automatic add3();    set_id(1, 1, 2, 1, 1, 3, 1, 0); endtask
   task automatic sub4();    set_id(1, 3, 3, 1, 1, 4, 1, 0); endtask

   task automatic cyc(input string nm, input logic [4:0] c, input logic [1:0] fa,
                      input logic [1:0] fb, input int sc, input int fc, input int ssc);
      exp_t e;
      e.nm  = nm;
      e.ctl = {c, fa, fb};
      e.sc  = 16'(sc);
      e.fc  = 16'(fc);
      e.ssc = 4'(ssc);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; ex_branch_taken = 0; dmem_busy = 0; nop();
      @(posedge clk); #1;
      cyc("reset", C_RST, 2'b00, 2'b00, 0, 0, 0);
      rst = 0;
      // load-use: lw $8 then add $9,$8,$10
      lw8();  cyc("lw_id", C_RUN, 2'b00, 2'b00, 0, 0, 0);
      add9(); cyc("lu_stall", C_STALL, 2'b00, 2'b00, 0, 0, 0);
      add9(); cyc("lu_fwd_mem", C_RUN, 2'b10, 2'b00, 1, 0, 1);
      nop();  cyc("lu_fwd_wb", C_RUN, 2'b01, 2'b00, 1, 0, 1);
      cyc("drain1", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      cyc("drain2", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      // back-to-back ALU dependency, then one instruction apart
      add3(); cyc("add3_id", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      sub4(); cyc("sub_id", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      nop();  cyc("sub_fwd_mem", C_RUN, 2'b10, 2'b10, 1, 0, 1);
      cyc("drain3", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      add3(); cyc("add3_id_b", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      set_id(1, 6, 7, 1, 1, 5, 1, 0); cyc("indep_id", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      sub4(); cyc("sub_id_b", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      nop();  cyc("sub_fwd_wb", C_RUN, 2'b01, 2'b01, 1, 0, 1);
      cyc("drain4", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      cyc("drain5", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      // load into $0 followed by a reader of $0
      set_id(1, 1, 0, 1, 0, 0, 1, 1); cyc("lw0_id", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      set_id(1, 0, 0, 1, 1, 9, 1, 0); cyc("r0_no_stall", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      nop(); cyc("r0_no_fwd_mem", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      cyc("r0_no_fwd_wb", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      cyc("drain6", C_RUN, 2'b00, 2'b00, 1, 0, 1);
      rst = 1; cyc("reset_mid", C_RST, 2'b00, 2'b00, 1, 0, 1);
      rst = 0;
      // taken branch overrides a load-use match
      lw8();  cyc("br_lw_id", C_RUN, 2'b00, 2'b00, 0, 0, 0);
      add9(); ex_branch_taken = 1; cyc("br_over_lu", C_BR, 2'b00, 2'b00, 0, 0, 0);
      ex_branch_taken = 0; nop(); cyc("br_after", C_RUN, 2'b10, 2'b00, 0, 1, 0);
      cyc("drain7", C_RUN, 2'b00, 2'b00, 0, 1, 0);
      cyc("drain8", C_RUN, 2'b00, 2'b00, 0, 1, 0);
      // memory freeze for three cycles over a load-use window
      lw8();  cyc("busy_lw_id", C_RUN, 2'b00, 2'b00, 0, 1, 0);
      add9(); dmem_busy = 1; cyc("busy1", C_HOLD, 2'b00, 2'b00, 0, 1, 0);
      ex_branch_taken = 1; cyc("busy2_br", C_HOLD, 2'b00, 2'b00, 0, 1, 0);
      ex_branch_taken = 0; cyc("busy3", C_HOLD, 2'b00, 2'b00, 0, 1, 0);
      dmem_busy = 0; cyc("busy_lu_stall", C_STALL, 2'b00, 2'b00, 0, 1, 0);
      cyc("busy_fwd_mem", C_RUN, 2'b10, 2'b00, 1, 1, 1);
      nop(); cyc("busy_fwd_wb", C_RUN, 2'b01, 2'b00, 1, 1, 1);
      cyc("drain9", C_RUN, 2'b00, 2'b00, 1, 1, 1);
      cyc("drain10", C_RUN, 2'b00, 2'b00, 1, 1, 1);
      // repeated stalls drive the 4-bit counter into saturation
      lw8(); cyc("sat_lw_id", C_RUN, 2'b00, 2'b00, 1, 1, 1);
      for (int i = 1; i <= 16; i++) begin
         add9(); cyc("sat_stall", C_STALL, 2'b00, 2'b00, i, 1, (i > 15) ? 15 : i);
         lw8();  cyc("sat_fwd", C_RUN, 2'b10, 2'b00, i + 1, 1, (i + 1 > 15) ? 15 : i + 1);
      end
      add9(); cyc("last_stall", C_STALL, 2'b00, 2'b00, 17, 1, 15);
      rst = 1; cyc("rst_in_load_stall", C_RST, 2'b00, 2'b00, 18, 1, 15);
      rst = 0; nop(); cyc("post_rst", C_RUN, 2'b00, 2'b00, 0, 0, 0);
      @(negedge clk); #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each performance counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port id_valid, input, 1, meaning the ID stage holds a real instruction.
REQ-005 The block SHALL have ports id_rs and id_rt, input, 5 each, the ID-stage source registers.
REQ-006 The block SHALL have ports id_uses_rs and id_uses_rt, input, 1 each, meaning the ID instruction reads that source.
REQ-007 The block SHALL have ports id_dst (input, 5), id_regwrite (input, 1) and id_memread (input, 1), the ID-stage destination and control.
REQ-008 The block SHALL have port ex_branch_taken, input, 1, meaning the branch in EX resolved taken.
REQ-009 The block SHALL have port dmem_busy, input, 1, meaning data memory requests a freeze this cycle.
REQ-010 The block SHALL have ports pc_write and ifid_write, output, 1 each, enabling PC and IF/ID updates.
REQ-011 The block SHALL have port ifid_flush, output, 1, to zero IF/ID at the next edge.
REQ-012 The block SHALL have port idex_bubble, output, 1, to load a NOP into ID/EX.
REQ-013 The block SHALL have port pipe_hold, output, 1, to freeze ID/EX, EX/MEM and MEM/WB.
REQ-014 The block SHALL have ports fwd_a and fwd_b, output, 2 each, EX operand selects: 00 = register file, 01 = WB, 10 = MEM.
REQ-015 The block SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, performance counters.

Function
REQ-016 The block SHALL keep trackers for EX, MEM and WB, each holding {valid, rs, rt, dst, regwrite, memread}.
REQ-017 When pipe_hold=0, trackers SHALL shift each cycle: ID to EX, EX to MEM, MEM to WB.
REQ-018 When idex_bubble=1, the EX tracker SHALL load as invalid.
REQ-019 The state machine SHALL have states RUN, LOAD_STALL and MEM_WAIT.
REQ-020 Priority SHALL be: dmem_busy, then ex_branch_taken, then load-use, then RUN.
REQ-021 dmem_busy=1 SHALL set pipe_hold=1, pc_write=0, ifid_write=0, ifid_flush=0 and idex_bubble=0, SHALL enter MEM_WAIT, and SHALL leave all trackers unchanged.
REQ-022 In MEM_WAIT, the first cycle with dmem_busy=0 SHALL return to RUN, and hazards SHALL be re-evaluated in that same cycle.
REQ-023 When ex_branch_taken=1 and dmem_busy=0, the block SHALL assert ifid_flush=1 and idex_bubble=1, keep pc_write=1, increment flush_cnt once, and override any load-use stall.
REQ-024 Load-use SHALL be detected when EX.valid and EX.memread and EX.dst≠0 and ((id_uses_rs and id_rs=EX.dst) or (id_uses_rt and id_rt=EX.dst)) and id_valid.
REQ-025 On load-use, the block SHALL set pc_write=0, ifid_write=0 and idex_bubble=1 for exactly one cycle, pass through LOAD_STALL, and increment stall_cnt once.
REQ-026 On the cycle after LOAD_STALL, the load SHALL be in MEM, no second stall SHALL occur, and fwd SHALL select MEM.
REQ-027 In RUN with no hazard, the block SHALL set pc_write=1, ifid_write=1, and ifid_flush, idex_bubble and pipe_hold to 0.
REQ-028 fwd_a SHALL be 10 if MEM.valid and MEM.regwrite and MEM.dst≠0 and MEM.dst=EX.rs.
REQ-029 Otherwise fwd_a SHALL be 01 if the same condition holds for WB.
REQ-030 Otherwise fwd_a SHALL be 00; fwd_b SHALL be computed identically using EX.rt.
REQ-031 Register $0 SHALL never be forwarded.
REQ-032 The register file SHALL write before it reads, so no ID-stage forwarding is needed.
REQ-033 All outputs except counters SHALL be combinational from trackers, state and inputs.
REQ-034 Counters SHALL saturate at all-ones and not wrap.

Reset
REQ-035 While rst=1, the block SHALL drive pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, fwd_a=fwd_b=00; state SHALL be RUN, all trackers invalid, counters 0.
REQ-036 Reset mid-stall or mid-MEM_WAIT SHALL discard the pending condition, with no counter increment.

Structure
REQ-037 A shared package SHALL hold the state enum, the fwd encoding constants (FWD_RF, FWD_WB, FWD_MEM) and the tracker struct type.
REQ-038 Forwarding compare logic SHALL be one sub-module, forward_select, instantiated twice (operands a and b).

Verification
REQ-039 lw $8 then add $9,$8,$10 (id_uses_rs=1): one cycle of pc_write=0 and idex_bubble=1, then fwd_a=10, stall_cnt=1.
REQ-040 add $3,$1,$2; sub $4,$3,$3: fwd_a=fwd_b=10 in the sub's EX cycle; then with one independent instruction between them, fwd_a=fwd_b=01.
REQ-041 Writer targets $0 followed by a reader of $0: fwd_a=00, no stall.
REQ-042 ex_branch_taken=1 in the same cycle as a load-use match: ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt=0.
REQ-043 dmem_busy high for 3 cycles during a load-use window: pipe_hold=1 for 3 cycles with trackers frozen, then the single load-use stall; stall_cnt=1.
REQ-044 Preload stall_cnt to 0xFFFF, then cause a load-use: stall_cnt stays 0xFFFF; rst=1 mid-LOAD_STALL: all counters read 0 on the next cycle.
